// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    // Divide by zero yields LO = all ones; replicated to the unit's WIDTH.
    localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t             state, state_next;
    op_t                op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [WIDTH-1:0]   opnd, orig_a;
    logic               res_neg, rem_neg, div0;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a, abs_b;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   addend, diff;
    logic [WIDTH:0]     rem_shift;
    logic               ge;

    logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

    // Counter holds WIDTH-1 during the last RUN cycle; it reaches WIDTH on entry to FINISH.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        signed_op = (op == MULT) || (op == DIV);
        abs_a     = (signed_op && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        abs_b     = (signed_op && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    end

    // One iteration: multiply adds into the upper half then shifts right;
    // divide shifts left and subtracts the divisor when it fits.
    always_comb begin
        addend    = '0;
        sum       = '0;
        rem_shift = '0;
        diff      = '0;
        ge        = 1'b0;
        acc_step  = acc;
        if (op_q == MULT || op_q == MULTU) begin
            addend   = acc[0] ? opnd : '0;
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
            acc_step = {sum, acc[WIDTH-1:1]};
        end else begin
            rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            ge        = rem_shift[WIDTH] || (rem_shift[WIDTH-1:0] >= opnd);
            diff      = rem_shift[WIDTH-1:0] - opnd;
            if (ge) acc_step = {diff, acc[WIDTH-2:0], 1'b1};
            else    acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod   = res_neg ? -acc : acc;
        quot   = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_q == DIV || op_q == DIVU) begin
            if (div0) begin
                res_hi = orig_a;
                res_lo = {WIDTH{DIV0_LO_BIT}};
            end else begin
                res_hi = rem_neg ? -rem : rem;
                res_lo = res_neg ? -quot : quot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            orig_a  <= '0;
            op_q    <= MULT;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= op_t'(op);
                        cnt     <= '0;
                        orig_a  <= SrcA;
                        res_neg <= signed_op && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        rem_neg <= signed_op && SrcA[WIDTH-1];
                        div0    <= (SrcB == '0);
                        if (op[1]) begin
                            opnd <= abs_b;
                            acc  <= {{WIDTH{1'b0}}, abs_a};
                        end else begin
                            opnd <= abs_a;
                            acc  <= {{WIDTH{1'b0}}, abs_b};
                        end
                    end else begin
                        if (mthi) hi <= SrcA;
                        if (mtlo) lo <= SrcA;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: vector table for results and latency, plus
// hand sequences for mid-operation interference, MTHI/MTLO and reset abort.
module tb_mult_div;
    import mult_div_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] SrcA, SrcB;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .SrcA (SrcA),
        .SrcB (SrcB),
        .mthi (mthi),
        .mtlo (mtlo),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns at the negedge of cycle 1, with operands scrambled after capture.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; SrcA = a; SrcB = b;
        @(negedge clk);
        start = 1'b0; op = ~o; SrcA = ~a; SrcB = ~b;
    endtask

    task automatic wait_done(input int first, output int lat, output int busy_low);
        lat = first;
        busy_low = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, busy_low, done_cnt;

        vecs[0]  = '{"multu_max",   MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg3x7", MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_neg7_2",  DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"div_minneg1", DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{"divu_by0",    DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{"div_neg_by0", DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[6]  = '{"multu_2p16",  MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7]  = '{"mult_minsq",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{"divu_by1",    DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[9]  = '{"div_7_neg2",  DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{"mult_zero",   MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        vecs[11] = '{"divu_small",  DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);

        foreach (vecs[i]) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1, lat, busy_low);
            check({vecs[i].name, "_latency"}, lat, 34);
            check({vecs[i].name, "_busy_run"}, busy_low, 0);
            check({vecs[i].name, "_busy_at_done"}, busy, 0);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, done, 0);
        end

        // start and mthi mid-operation are ignored
        launch(DIVU, 32'd10, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; mthi = 1'b1; op = MULT; SrcA = 32'h1234; SrcB = 32'h5;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_done(6, lat, busy_low);
        check("ignore_latency", lat, 34);
        check("ignore_busy_run", busy_low, 0);
        check("ignore_lo", lo, 3);
        check("ignore_hi", hi, 1);

        @(negedge clk);
        mthi = 1'b1; SrcA = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo", lo, 3);
        check("mthi_no_done", done, 0);
        check("mthi_no_busy", busy, 0);

        mthi = 1'b1; mtlo = 1'b1; SrcA = 32'hABCD;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", hi, 32'hABCD);
        check("mt_both_lo", lo, 32'hABCD);

        // start wins over MT writes in the same cycle
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = DIVU; SrcA = 32'd10; SrcB = 32'd3;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("prio_hi_kept", hi, 32'hABCD);
        check("prio_lo_kept", lo, 32'hABCD);
        check("prio_busy", busy, 1);
        wait_done(1, lat, busy_low);
        check("prio_latency", lat, 34);
        check("prio_hi", hi, 1);
        check("prio_lo", lo, 3);

        // reset during an operation aborts it without done
        launch(MULT, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        done_cnt = 0;
        repeat (40) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", done_cnt, 0);

        launch(MULT, 32'd5, 32'd5);
        wait_done(1, lat, busy_low);
        check("after_abort_latency", lat, 34);
        check("after_abort_hi", hi, 0);
        check("after_abort_lo", lo, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
